regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_fsm.sv | 59 +++++
 rtl/regfile_param.sv | 95 +++++++++
 tb/tb_regfile_param.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parameterised register file.
// Optional macro: REGFILE_BYPASS_EN (see regfile_param.sv).
package regfile_pkg;

    // Clear-sweep controller states
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 8;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: on a sampled clr_req walks ptr from 0 to DEPTH-1,
// asserting sweep_we so the storage zeroes one register per cycle.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] ptr,
    output logic              sweep_we
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    clr_state_t state;

    // State, pointer and registered outputs advance together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            busy     <= 1'b0;
            sweep_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= SWEEP;
                        ptr      <= '0;
                        busy     <= 1'b1;
                        sweep_we <= 1'b1;
                    end
                end
                SWEEP: begin
                    // clr_req is not looked at here, so it cannot extend a sweep
                    if (ptr == LAST) begin
                        state    <= IDLE;
                        ptr      <= '0;
                        busy     <= 1'b0;
                        sweep_we <= 1'b0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    ptr      <= '0;
                    busy     <= 1'b0;
                    sweep_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parameterised 2-read/1-write register file with a clear sweep.
// Optional macro: REGFILE_BYPASS_EN -- a read of the address being written by
// a committing write returns write_data in the same cycle.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  int unsigned ZERO_REG = 0,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic              sweep_we;
    logic              zero_hit;
    logic              wr_commit;

    // Writes to the hard-wired zero register are silently ignored, not dropped
    assign zero_hit  = (ZERO_REG != 0) && (write_addr == '0);
    assign wr_commit = we && !busy && !zero_hit;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .ptr      (ptr),
        .sweep_we (sweep_we)
    );

    // Storage: sweep clears have priority; user writes only commit while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (sweep_we) begin
            regs[ptr] <= '0;
        end else if (wr_commit) begin
            regs[write_addr] <= write_data;
        end
    end

    // Flag a write that arrived during a sweep, one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= we && busy;
        end
    end

    // Read port 1: array lookup, optional bypass, zero-reg and reset masking
    always_comb begin
        read_data1 = regs[read_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_commit && (read_addr1 == write_addr)) begin
            read_data1 = write_data;
        end
`endif
        if (reset || ((ZERO_REG != 0) && (read_addr1 == '0))) begin
            read_data1 = '0;
        end
    end

    // Read port 2: same path as port 1
    always_comb begin
        read_data2 = regs[read_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_commit && (read_addr2 == write_addr)) begin
            read_data2 = write_data;
        end
`endif
        if (reset || ((ZERO_REG != 0) && (read_addr2 == '0))) begin
            read_data2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: two instances (ZERO_REG=0 and 1)
// share all inputs and are compared against a behavioural model.
module tb_regfile_param;

    localparam int DEPTH = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       we = 1'b0;
    logic       clr_req = 1'b0;
    logic [2:0] write_addr = '0;
    logic [7:0] write_data = '0;
    logic [2:0] ra1 = '0;
    logic [2:0] ra2 = '0;
    logic [7:0] rd1, rd2, zrd1, zrd2;
    logic       busy, wr_drop, zbusy, zdrop;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: register contents and cycles of sweep still to run
    logic [7:0] m_mem [DEPTH];
    logic [7:0] z_mem [DEPTH];
    int         m_left = 0;
    bit         m_drop = 1'b0;

    regfile_param #(.DATA_W(8), .DEPTH(8), .ZERO_REG(0)) dut (
        .clk(clk), .reset(reset), .we(we), .write_addr(write_addr),
        .write_data(write_data), .read_addr1(ra1), .read_addr2(ra2),
        .read_data1(rd1), .read_data2(rd2), .clr_req(clr_req),
        .busy(busy), .wr_drop(wr_drop)
    );

    regfile_param #(.DATA_W(8), .DEPTH(8), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .we(we), .write_addr(write_addr),
        .write_data(write_data), .read_addr1(ra1), .read_addr2(ra2),
        .read_data1(zrd1), .read_data2(zrd2), .clr_req(clr_req),
        .busy(zbusy), .wr_drop(zdrop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [2:0] a, input bit zr);
        if (reset) return 8'h00;
        if (zr && a == 3'd0) return 8'h00;
        if (BYP && we && m_left == 0 && a == write_addr && !(zr && write_addr == 3'd0))
            return write_data;
        return zr ? z_mem[a] : m_mem[a];
    endfunction

    task automatic check_all();
        chk("rd1", rd1, exp_rd(ra1, 1'b0));
        chk("rd2", rd2, exp_rd(ra2, 1'b0));
        chk("busy", busy, m_left != 0);
        chk("wr_drop", wr_drop, m_drop);
        chk("z_rd1", zrd1, exp_rd(ra1, 1'b1));
        chk("z_rd2", zrd2, exp_rd(ra2, 1'b1));
        chk("z_busy", zbusy, m_left != 0);
        chk("z_wr_drop", zdrop, m_drop);
    endtask

    // Apply the rules for one rising edge to the model
    task automatic model_edge();
        int idx;
        m_drop = we && (m_left != 0);
        if (m_left != 0) begin
            idx = DEPTH - m_left;
            m_mem[idx] = 8'h00;
            z_mem[idx] = 8'h00;
            m_left--;
        end else begin
            if (we) begin
                m_mem[write_addr] = write_data;
                if (write_addr != 3'd0) z_mem[write_addr] = write_data;
            end
            if (clr_req) m_left = DEPTH;
        end
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input bit w, input int wa, input int wd,
                          input int a1, input int a2, input bit c);
        we = w;
        write_addr = 3'(wa);
        write_data = 8'(wd);
        ra1 = 3'(a1);
        ra2 = 3'(a2);
        clr_req = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we = 1'b1;
        write_addr = 3'd3;
        write_data = 8'hEE;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 8'h00;
            z_mem[i] = 8'h00;
        end
        m_left = 0;
        m_drop = 1'b0;
        for (int a = 0; a < DEPTH; a += 2) begin
            ra1 = 3'(a);
            ra2 = 3'(a + 1);
            #1;
            check_all();
        end
        we = 1'b0;
        clr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_all();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, i, 8'h11 * (i + 1), i, (i + 1) % DEPTH, 1'b0);
            step();
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        chk("sweep_end_bound", busy, 1'b0);
    endtask

    initial begin
        int cnt;

        do_reset();

        // Fill every register, then read back in pairs
        write_all();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 0, 0, 2 * k, 2 * k + 1, 1'b0);
            #1;
            chk("fill_rd1", rd1, 8'h11 * (2 * k + 1));
            chk("fill_rd2", rd2, 8'h11 * (2 * k + 2));
            step();
        end

        // One-cycle clear pulse: busy for exactly DEPTH cycles, all zero after
        set_in(1'b0, 0, 0, 0, 1, 1'b1);
        step();
        clr_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        chk("sweep_cycles", cnt, DEPTH);
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 0, 0, 2 * k, 2 * k + 1, 1'b0);
            #1;
            chk("clear_rd1", rd1, 8'h00);
            chk("clear_rd2", rd2, 8'h00);
            step();
        end

        // Write during the sweep is dropped and flagged for one cycle
        write_all();
        set_in(1'b0, 0, 0, 3, 0, 1'b1);
        step();
        set_in(1'b1, 3, 8'hAA, 3, 0, 1'b0);
        step();
        set_in(1'b0, 0, 0, 3, 0, 1'b0);
        #1;
        chk("drop_pulse", wr_drop, 1'b1);
        step();
        #1;
        chk("drop_once", wr_drop, 1'b0);
        wait_idle();
        #1;
        chk("drop_reg3", rd1, 8'h00);
        step();

        // Same-cycle read of the address being written
        set_in(1'b1, 2, 8'h33, 0, 0, 1'b0);
        step();
        set_in(1'b1, 2, 8'h5C, 2, 0, 1'b0);
        #1;
        chk("bypass_rd1", rd1, BYP ? 8'h5C : 8'h33);
        step();
        set_in(1'b0, 0, 0, 2, 0, 1'b0);
        #1;
        chk("after_edge_rd1", rd1, 8'h5C);
        step();

        // Reset in the fourth sweep cycle
        write_all();
        set_in(1'b0, 0, 0, 0, 1, 1'b1);
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 3; k++) step();
        do_reset();
        chk("rst_busy", busy, 1'b0);
        set_in(1'b1, 5, 8'h3C, 5, 0, 1'b0);
        step();
        set_in(1'b0, 0, 0, 5, 0, 1'b0);
        #1;
        chk("post_rst_write", rd1, 8'h3C);
        step();

        // Hard-wired zero register
        set_in(1'b1, 0, 8'hFF, 0, 0, 1'b0);
        step();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        #1;
        chk("zero_reg_rd", zrd1, 8'h00);
        chk("zero_reg_drop", zdrop, 1'b0);
        chk("normal_reg0_rd", rd1, 8'hFF);
        step();

        // clr_req held high: back-to-back sweeps with one idle cycle between
        write_all();
        set_in(1'b1, 4, 8'h99, 4, 1, 1'b1);
        for (int k = 0; k < 22; k++) begin
            write_data = 8'($urandom_range(0, 255));
            write_addr = 3'($urandom_range(0, 7));
            step();
        end
        clr_req = 1'b0;
        we = 1'b0;
        wait_idle();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                set_in(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       $urandom_range(0, 255), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 99) < 6);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
